uart_seg_console: RTL

- Parametrised ASCII console layer between a UART receiver and a multi-digit 7-segment driver.
- Consumes one received byte per `rx_valid` pulse and keeps a wrapping cursor over DIGIT_CT digits.
- Decodes printable characters, control characters and a `#HH` brightness escape into driver write/clear strobes.
- Optionally echoes each byte back through a UART transmitter handshake.

---
 rtl/uart_seg_console.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_seg_console.sv
// uart_seg_console: ASCII console layer between a UART receiver and a
// multi-digit 7-segment driver. Printable hex/space/dash/dot bytes become
// commit strobes at a wrapping cursor; BS, CR, FF and a '#HH' brightness
// escape are handled as controls.
//
// Build option UART_SEG_CONSOLE_ECHO_EN: when defined, every consumed byte is
// echoed through the tx_load/tx_load_ok handshake. When undefined, the echo
// state is absent, tx_data/tx_load are held at 0 and tx_load_ok is ignored.
//
// state  | meaning
// IDLE   | waiting for an enabled rx byte
// DECODE | classify latched byte, move cursor, prepare glyph
// WRITE  | commit strobe with registered seg_out/char_sel
// ESC_HI | '#' seen, waiting for the high brightness nibble
// ESC_LO | waiting for the low brightness nibble
// ECHO   | hold tx_data until the transmitter accepts it (echo builds only)

module uart_seg_console #(
  parameter int DIGIT_CT = 8,
  parameter int SEG_CT   = 8,
  parameter int DIM_W    = 8,
  parameter int BYTE_W   = 8
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [BYTE_W-1:0]           rx_data,
  input  logic                        rx_valid,
  input  logic                        tx_load_ok,
  input  logic                        clr_overrun,
  output logic [SEG_CT-1:0]           seg_out,
  output logic [$clog2(DIGIT_CT)-1:0] char_sel,
  output logic                        commit,
  output logic                        clear_buf,
  output logic [DIM_W-1:0]            brightness,
  output logic [$clog2(DIGIT_CT)-1:0] cursor,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_load,
  output logic                        busy,
  output logic                        overrun
);

  localparam int CW = $clog2(DIGIT_CT);
  localparam logic [CW-1:0] LAST_POS = CW'(DIGIT_CT - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_QUERY = 8'h3F;

`ifdef UART_SEG_CONSOLE_ECHO_EN
  typedef enum logic [2:0] {IDLE, DECODE, WRITE, ESC_HI, ESC_LO, ECHO} state_t;
  // Every finished byte passes through ECHO on its way back to IDLE.
  localparam state_t DONE = ECHO;
`else
  typedef enum logic [2:0] {IDLE, DECODE, WRITE, ESC_HI, ESC_LO} state_t;
  localparam state_t DONE = IDLE;
`endif

  state_t state_q, state_d;

  logic [7:0]        byte_q;
  logic [CW-1:0]     cursor_q;
  logic [CW-1:0]     cursor_inc;
  logic [CW-1:0]     cursor_dec;
  logic [SEG_CT-1:0] seg_q;
  logic [CW-1:0]     sel_q;
  logic              clear_q;
  logic [DIM_W-1:0]  bright_q;
  logic [DIM_W-1:0]  bright_new;
  logic [3:0]        hi_nib_q;
  logic [7:0]        esc_val;
  logic              overrun_q;
  logic              overrun_set;

  logic [4:0]        hex_lat;
  logic [4:0]        hex_rx;
  logic              is_glyph;
  logic [7:0]        glyph;

  // {valid, value} for an ASCII hex digit of either case
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  // Standard hex glyphs, bit order {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'h3F;
      4'h1: g = 8'h06;
      4'h2: g = 8'h5B;
      4'h3: g = 8'h4F;
      4'h4: g = 8'h66;
      4'h5: g = 8'h6D;
      4'h6: g = 8'h7D;
      4'h7: g = 8'h07;
      4'h8: g = 8'h7F;
      4'h9: g = 8'h6F;
      4'hA: g = 8'h77;
      4'hB: g = 8'h7C;
      4'hC: g = 8'h39;
      4'hD: g = 8'h5E;
      4'hE: g = 8'h79;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  // Classify the latched byte and the live rx byte
  always_comb begin
    hex_lat  = hex_decode(byte_q);
    hex_rx   = hex_decode(rx_data);
    is_glyph = 1'b1;
    glyph    = 8'h00;
    if (hex_lat[4])
      glyph = hex_glyph(hex_lat[3:0]);
    else if (byte_q == CH_SP)
      glyph = 8'h00;
    else if (byte_q == CH_DASH)
      glyph = 8'h40;
    else if (byte_q == CH_DOT)
      glyph = 8'h80;
    else
      is_glyph = 1'b0;
  end

  // Explicit modulo wrap so non-power-of-two digit counts behave
  always_comb begin
    cursor_inc = (cursor_q == LAST_POS) ? '0 : cursor_q + 1'b1;
    cursor_dec = (cursor_q == '0) ? LAST_POS : cursor_q - 1'b1;
  end

  assign esc_val = {hi_nib_q, hex_rx[3:0]};

  // Narrow outputs keep the top bits of the escape value, wide ones pad below
  if (DIM_W <= 8) begin : g_bright_narrow
    assign bright_new = esc_val[7 -: DIM_W];
  end else begin : g_bright_wide
    assign bright_new = {esc_val, {(DIM_W - 8){1'b0}}};
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_valid && en)
          state_d = DECODE;
      end
      DECODE: begin
        if (is_glyph || byte_q == CH_BS)
          state_d = WRITE;
        else if (byte_q == CH_HASH)
          state_d = ESC_HI;
        else
          state_d = DONE;
      end
      WRITE: state_d = DONE;
      ESC_HI: begin
        if (rx_valid)
          state_d = hex_rx[4] ? ESC_LO : DONE;
      end
      ESC_LO: begin
        if (rx_valid)
          state_d = DONE;
      end
`ifdef UART_SEG_CONSOLE_ECHO_EN
      ECHO: begin
        if (tx_load_ok)
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Byte latch, cursor, display write data, clear strobe and brightness
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= '0;
      cursor_q <= '0;
      seg_q    <= '0;
      sel_q    <= '0;
      clear_q  <= 1'b0;
      bright_q <= '1;
      hi_nib_q <= '0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid && en)
            byte_q <= rx_data;
        end
        DECODE: begin
          if (is_glyph) begin
            seg_q    <= SEG_CT'(glyph);
            sel_q    <= cursor_q;
            cursor_q <= cursor_inc;
          end else if (byte_q == CH_BS) begin
            // Backspace blanks the cell it steps back onto and stays there
            seg_q    <= '0;
            sel_q    <= cursor_dec;
            cursor_q <= cursor_dec;
          end else if (byte_q == CH_CR) begin
            cursor_q <= '0;
          end else if (byte_q == CH_FF) begin
            clear_q  <= 1'b1;
            cursor_q <= '0;
          end
        end
        ESC_HI: begin
          if (rx_valid && hex_rx[4])
            hi_nib_q <= hex_rx[3:0];
        end
        ESC_LO: begin
          if (rx_valid && hex_rx[4])
            bright_q <= bright_new;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_SEG_CONSOLE_ECHO_EN
  logic [7:0] tx_byte_q;

  // Echo byte: the accepted byte, the escape terminator, or '?' on abort
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && en)
            tx_byte_q <= rx_data;
        end
        ESC_HI: begin
          if (rx_valid && !hex_rx[4])
            tx_byte_q <= CH_QUERY;
        end
        ESC_LO: begin
          if (rx_valid)
            tx_byte_q <= hex_rx[4] ? rx_data : CH_QUERY;
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = tx_byte_q;
  assign tx_load     = (state_q == ECHO) && tx_load_ok;
  assign overrun_set = rx_valid &&
                       (state_q == DECODE || state_q == WRITE || state_q == ECHO);
`else
  logic unused_tx_load_ok;
  assign unused_tx_load_ok = tx_load_ok;
  assign tx_data     = '0;
  assign tx_load     = 1'b0;
  assign overrun_set = rx_valid && (state_q == DECODE || state_q == WRITE);
`endif

  // Sticky overrun; a simultaneous set beats the clear
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      overrun_q <= 1'b0;
    else if (overrun_set)
      overrun_q <= 1'b1;
    else if (clr_overrun)
      overrun_q <= 1'b0;
  end

  assign seg_out    = seg_q;
  assign char_sel   = sel_q;
  assign commit     = (state_q == WRITE);
  assign clear_buf  = clear_q;
  assign brightness = bright_q;
  assign cursor     = cursor_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule
